// File: rtl/jtag_cmd_ctrl.sv
`timescale 1ns/1ps
// jtag_cmd_ctrl
// Decodes byte frames from a serial receiver into register-port accesses.
// A frame is a header {RW, AINC, LEN[5:0]}, an address byte, then LEN+1
// payload bytes. Writes turn each received payload byte into a reg_wr
// strobe. Reads fetch registers ahead of the transmitter through a one-byte
// prefetch buffer, so tx_data can be reloaded on every tx_done.
//
// Ports
//   TCK        clock, all state changes on the rising edge
//   TCS        chip select, asynchronous active-high reset / frame abort
//   rx_data    received byte, valid while rx_done=1
//   rx_done    one-cycle pulse per received byte
//   tx_done    one-cycle pulse when the transmitter shifts its last bit
//   reg_rdata  register read data, valid one cycle after reg_rd
//   reg_addr   register address
//   reg_wdata  register write data
//   reg_wr     one-cycle write strobe
//   reg_rd     one-cycle read strobe
//   tx_data    byte presented to the transmitter (registered)
//   tx_en      high while read payload is being transmitted
//   busy       high from header accepted until frame complete
//   err        sticky protocol error, cleared only by TCS
module jtag_cmd_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              TCK,
    input  logic              TCS,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [7:0]        reg_rdata,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] S_HDR    = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_RFETCH = 3'd3;
    localparam logic [2:0] S_RSEND  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state;
    logic              rw;
    logic              ainc;
    // Bytes still to move after the current one.
    logic [5:0]        count;
    logic [7:0]        prefetch;
    // prefetch holds the byte that follows the one in tx_data.
    logic              pf_valid;
    // A reg_rd was issued last cycle; reg_rdata is valid this cycle.
    logic              rd_pend;
    logic [ADDR_W-1:0] rx_addr;
    logic              issue_rd;

    // Address byte is zero-extended or truncated to the port width.
    assign rx_addr = ADDR_W'(rx_data);

    // Fetch the next byte as soon as the buffer is free and another byte is
    // still owed; count==0 means the byte in tx_data is the last, so no read
    // is ever issued beyond LEN+1.
    assign issue_rd = (state == S_RSEND) && (count != 6'd0) && !pf_valid
                      && !reg_rd && !rd_pend;

    // NOTE: every register here, the prefetch buffer included, is a plain
    // flop cleared by TCS; all sequential updates use non-blocking '<=' so
    // each reads the pre-edge value of the others regardless of order.
    always_ff @(posedge TCK or posedge TCS) begin
        if (TCS) begin
            state     <= S_HDR;
            rw        <= 1'b0;
            ainc      <= 1'b0;
            count     <= 6'd0;
            prefetch  <= 8'd0;
            pf_valid  <= 1'b0;
            rd_pend   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'd0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            tx_data   <= 8'd0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            reg_wr  <= 1'b0;
            reg_rd  <= 1'b0;
            rd_pend <= reg_rd;

            // Address advances after each access strobe, wrapping naturally.
            if ((reg_wr || reg_rd) && ainc)
                reg_addr <= reg_addr + ADDR_W'(1);

            if (tx_done && (state != S_RSEND))
                err <= 1'b1;

            case (state)
                S_HDR: begin
                    if (rx_done) begin
                        rw    <= rx_data[7];
                        ainc  <= rx_data[6];
                        count <= rx_data[5:0];
                        busy  <= 1'b1;
                        state <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (rx_done) begin
                        reg_addr <= rx_addr;
                        if (rw) begin
                            // First read goes out with the address so byte 0
                            // reaches tx_data two cycles later.
                            reg_rd <= 1'b1;
                            state  <= S_RFETCH;
                        end else begin
                            state  <= S_WDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (rx_done) begin
                        reg_wdata <= rx_data;
                        reg_wr    <= 1'b1;
                        if (count == 6'd0) begin
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            count <= count - 6'd1;
                        end
                    end
                end

                S_RFETCH: begin
                    if (rx_done)
                        err <= 1'b1;
                    if (rd_pend) begin
                        prefetch <= reg_rdata;
                        tx_data  <= reg_rdata;
                        tx_en    <= 1'b1;
                        state    <= S_RSEND;
                    end
                end

                S_RSEND: begin
                    if (rx_done)
                        err <= 1'b1;
                    if (tx_done) begin
                        if (count == 6'd0) begin
                            tx_en <= 1'b0;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            tx_data  <= prefetch;
                            pf_valid <= 1'b0;
                            count    <= count - 6'd1;
                        end
                    end
                    // Returning read data marks the buffer full; placed after
                    // the tx_done branch so a fill is never lost.
                    if (rd_pend) begin
                        prefetch <= reg_rdata;
                        pf_valid <= 1'b1;
                    end
                    if (issue_rd)
                        reg_rd <= 1'b1;
                end

                S_DONE: begin
                    if (rx_done)
                        err <= 1'b1;
                end

                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_cmd_ctrl.sv
`timescale 1ns/1ps
// tb_jtag_cmd_ctrl
// Directed bench for jtag_cmd_ctrl: writes, read bursts, abort, protocol
// errors. A negedge monitor logs register strobes and models the register
// file (read data = address + 1, one cycle after reg_rd).
module tb_jtag_cmd_ctrl;

    localparam int ADDR_W = 8;

    logic              TCK = 1'b0;
    logic              TCS = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_done = 1'b0;
    logic              tx_done = 1'b0;
    logic [7:0]        reg_rdata = 8'd0;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              busy;
    logic              err;

    jtag_cmd_ctrl #(.ADDR_W(ADDR_W)) dut (
        .TCK       (TCK),
        .TCS       (TCS),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_done   (tx_done),
        .reg_rdata (reg_rdata),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .busy      (busy),
        .err       (err)
    );

    always #5 TCK = ~TCK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_addr_log [256];
    logic [7:0] wr_data_log [256];
    logic [7:0] rd_addr_log [256];
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int overlap = 0;

    always @(negedge TCK) begin
        if (reg_wr) begin
            wr_addr_log[wr_cnt] = reg_addr;
            wr_data_log[wr_cnt] = reg_wdata;
            wr_cnt++;
        end
        if (reg_rd) begin
            rd_addr_log[rd_cnt] = reg_addr;
            rd_cnt++;
            reg_rdata = reg_addr + 8'd1;
        end
        if (reg_wr && reg_rd)
            overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the edge that sampled rx_done.
    task automatic send(input logic [7:0] b);
        @(posedge TCK); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge TCK); #1;
        rx_done = 1'b0;
    endtask

    task automatic txd();
        @(posedge TCK); #1;
        tx_done = 1'b1;
        @(posedge TCK); #1;
        tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge TCK);
        #1;
    endtask

    task automatic frame_reset();
        TCS = 1'b1;
        #2;
        TCS = 1'b0;
    endtask

    logic [28:0] out_bus;
    assign out_bus = {reg_addr, reg_wdata, reg_wr, reg_rd, tx_data, tx_en, busy, err};

    int wb;
    int rb;

    initial begin
        // Reset state while TCS is held high
        #12;
        check("reset_outputs", 32'(out_bus), 32'd0);
        TCS = 1'b0;

        // Single write: 0x00, 0x10, 0xA5
        wb = wr_cnt;
        send(8'h00);
        check("busy_after_hdr", 32'(busy), 32'd1);
        send(8'h10);
        send(8'hA5);
        idle(2);
        check("wr1_count", 32'(wr_cnt - wb), 32'd1);
        check("wr1_addr", 32'(wr_addr_log[wb]), 32'h10);
        check("wr1_data", 32'(wr_data_log[wb]), 32'hA5);
        check("wr1_busy", 32'(busy), 32'd0);
        check("wr1_err", 32'(err), 32'd0);

        // Burst write with address increment wrapping past 0xFF
        frame_reset();
        wb = wr_cnt;
        send(8'h43);
        send(8'hFE);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        idle(2);
        check("wr4_count", 32'(wr_cnt - wb), 32'd4);
        check("wr4_addrs", {wr_addr_log[wb], wr_addr_log[wb+1], wr_addr_log[wb+2], wr_addr_log[wb+3]}, 32'hFEFF0001);
        check("wr4_data", {wr_data_log[wb], wr_data_log[wb+1], wr_data_log[wb+2], wr_data_log[wb+3]}, 32'h11223344);
        check("wr4_busy", 32'(busy), 32'd0);
        check("wr4_err", 32'(err), 32'd0);

        // Read burst: 0xC2, 0x20 -> 0x21, 0x22, 0x23
        frame_reset();
        rb = rd_cnt;
        send(8'hC2);
        send(8'h20);
        idle(3);
        check("rd3_byte0", 32'(tx_data), 32'h21);
        check("rd3_txen0", 32'(tx_en), 32'd1);
        idle(4);
        txd();
        check("rd3_byte1", 32'(tx_data), 32'h22);
        idle(4);
        txd();
        check("rd3_byte2", 32'(tx_data), 32'h23);
        check("rd3_txen2", 32'(tx_en), 32'd1);
        idle(4);
        txd();
        check("rd3_txen_end", 32'(tx_en), 32'd0);
        check("rd3_busy_end", 32'(busy), 32'd0);
        check("rd3_count", 32'(rd_cnt - rb), 32'd3);
        check("rd3_addrs", {8'h00, rd_addr_log[rb], rd_addr_log[rb+1], rd_addr_log[rb+2]}, 32'h00202122);
        check("rd3_err", 32'(err), 32'd0);

        // Read without address increment: 0x81, 0x05
        frame_reset();
        rb = rd_cnt;
        send(8'h81);
        send(8'h05);
        idle(3);
        check("rdn_byte0", 32'(tx_data), 32'h06);
        idle(4);
        txd();
        check("rdn_byte1", 32'(tx_data), 32'h06);
        check("rdn_txen1", 32'(tx_en), 32'd1);
        idle(2);
        txd();
        check("rdn_txen_end", 32'(tx_en), 32'd0);
        check("rdn_count", 32'(rd_cnt - rb), 32'd2);
        check("rdn_addrs", {16'h0000, rd_addr_log[rb], rd_addr_log[rb+1]}, 32'h00000505);

        // Abort after two of four burst write bytes
        frame_reset();
        wb = wr_cnt;
        send(8'h43);
        send(8'h30);
        send(8'h01);
        send(8'h02);
        idle(1);
        TCS = 1'b1;
        #1;
        check("abort_outputs", 32'(out_bus), 32'd0);
        idle(3);
        check("abort_wr_count", 32'(wr_cnt - wb), 32'd2);
        check("abort_addrs", {16'h0000, wr_addr_log[wb], wr_addr_log[wb+1]}, 32'h00003031);
        TCS = 1'b0;
        wb = wr_cnt;
        send(8'h00);
        send(8'h44);
        send(8'h5A);
        idle(2);
        check("post_abort_count", 32'(wr_cnt - wb), 32'd1);
        check("post_abort_write", {16'h0000, wr_addr_log[wb], wr_data_log[wb]}, 32'h0000445A);
        check("post_abort_busy", 32'(busy), 32'd0);

        // tx_done in HDR sets err, held until TCS
        frame_reset();
        txd();
        check("err_tx_hdr", 32'(err), 32'd1);
        idle(3);
        check("err_tx_hdr_held", 32'(err), 32'd1);
        frame_reset();
        check("err_cleared", 32'(err), 32'd0);

        // Extra rx_done during RSEND: err set, read sequence unchanged
        rb = rd_cnt;
        send(8'hC1);
        send(8'h40);
        idle(3);
        check("errr_byte0", 32'(tx_data), 32'h41);
        send(8'h99);
        check("errr_err", 32'(err), 32'd1);
        idle(4);
        txd();
        check("errr_byte1", 32'(tx_data), 32'h42);
        idle(2);
        txd();
        check("errr_txen_end", 32'(tx_en), 32'd0);
        check("errr_count", 32'(rd_cnt - rb), 32'd2);
        check("errr_err_held", 32'(err), 32'd1);

        check("no_wr_rd_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
